// File: rtl/pipe_column_gen.sv
// Obstacle column generator for the 30x40 shift-register playfield.
// Emits one 30-bit column per accepted game step: sky, or a pipe column with
// an LFSR-placed vertical gap. Also exports the current gap row and a
// saturating pipe counter for collision and score logic.
module pipe_column_gen #(
  parameter int          ROWS       = 30,
  parameter int          GAP_ROWS   = 8,
  parameter int          MARGIN     = 2,
  parameter int          PIPE_WIDTH = 3,
  parameter int          SPACING    = 12,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic            clk,
  input  logic            resetn,      // active-high asynchronous reset
  input  logic            enable,
  input  logic            step,
  output logic            col_valid,
  output logic [ROWS-1:0] col_data,
  output logic [4:0]      gap_top,
  output logic            pipe_start,
  output logic [7:0]      pipe_count
);

  // Number of legal gap positions; the 5-bit LFSR draw is folded into [0, R-1].
  localparam int R     = ROWS - GAP_ROWS - 2*MARGIN + 1;
  localparam int CNT_W = (SPACING > 1) ? $clog2(SPACING) : 1;

  // Elaboration-time parameter sanity checks.
  if (R < 16 || R > 32) begin : g_bad_range
    $error("pipe_column_gen: gap position range R=%0d must be within 16..32", R);
  end
  if (SPACING <= PIPE_WIDTH) begin : g_bad_spacing
    $error("pipe_column_gen: SPACING must exceed PIPE_WIDTH");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("pipe_column_gen: LFSR_SEED must be non-zero");
  end

  typedef enum logic {EMPTY, PIPE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] col_cnt, cnt_next;
  logic [15:0]      lfsr, lfsr_next;

  logic            vld_next;
  logic            start_next;
  logic [ROWS-1:0] data_next;
  logic [4:0]      gap_next;
  logic [7:0]      count_next;

  // Fold the low five LFSR bits into [0, R-1] (one subtraction suffices as
  // R >= 16) and offset by the solid margin above the gap.
  function automatic logic [4:0] draw_gap(input logic [15:0] l);
    logic [5:0] v;
    v = {1'b0, l[4:0]};
    if (v >= 6'(R)) v = v - 6'(R);
    return 5'(v + 6'(MARGIN));
  endfunction

  // Solid column with GAP_ROWS open rows starting at row 'top'.
  function automatic logic [ROWS-1:0] pipe_column(input logic [4:0] top);
    logic [ROWS-1:0] col;
    for (int r = 0; r < ROWS; r++) begin
      col[r] = !((r >= int'(top)) && (r < int'(top) + GAP_ROWS));
    end
    return col;
  endfunction

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left.
  function automatic logic [15:0] lfsr_advance(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Next column, counter, gap and LFSR for an accepted step; hold otherwise.
  always_comb begin
    state_next = state;
    cnt_next   = col_cnt;
    lfsr_next  = lfsr;
    vld_next   = 1'b0;
    start_next = 1'b0;
    data_next  = col_data;
    gap_next   = gap_top;
    count_next = pipe_count;

    if (enable && step) begin
      vld_next = 1'b1;
      if (state == PIPE && col_cnt == '0) begin
        gap_next   = draw_gap(lfsr);
        data_next  = pipe_column(draw_gap(lfsr));
        start_next = 1'b1;
        lfsr_next  = lfsr_advance(lfsr);
        if (pipe_count != 8'hFF) count_next = pipe_count + 8'd1;
      end else if (state == PIPE) begin
        data_next = pipe_column(gap_top);
      end else begin
        data_next = '0;
      end

      cnt_next   = (col_cnt == CNT_W'(SPACING-1)) ? '0 : col_cnt + 1'b1;
      state_next = (cnt_next < CNT_W'(PIPE_WIDTH)) ? PIPE : EMPTY;
    end
  end

  // Register control, LFSR and column outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state      <= EMPTY;
      col_cnt    <= CNT_W'(PIPE_WIDTH);
      lfsr       <= LFSR_SEED;
      col_valid  <= 1'b0;
      pipe_start <= 1'b0;
      col_data   <= '0;
      gap_top    <= '0;
      pipe_count <= '0;
    end else begin
      state      <= state_next;
      col_cnt    <= cnt_next;
      lfsr       <= lfsr_next;
      col_valid  <= vld_next;
      pipe_start <= start_next;
      col_data   <= data_next;
      gap_top    <= gap_next;
      pipe_count <= count_next;
    end
  end

endmodule

// File: tb/tb_pipe_column_gen.sv
// Self-checking bench for pipe_column_gen: directed sequences plus random
// enable/step traffic compared against a step-indexed behavioural model.
module tb_pipe_column_gen;

  localparam int          ROWS       = 30;
  localparam int          GAP_ROWS   = 8;
  localparam int          MARGIN     = 2;
  localparam int          PIPE_WIDTH = 3;
  localparam int          SPACING    = 12;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam int          R          = ROWS - GAP_ROWS - 2*MARGIN + 1;

  logic            clk;
  logic            resetn;
  logic            enable;
  logic            step;
  logic            col_valid;
  logic [ROWS-1:0] col_data;
  logic [4:0]      gap_top;
  logic            pipe_start;
  logic [7:0]      pipe_count;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: column index within the period, LFSR word,
  // current gap, pipe tally, and expected registered outputs.
  int          m_idx;
  int          m_lfsr;
  int          m_gap;
  int          m_count;
  longint      exp_data;
  int          exp_valid;
  int          exp_start;

  pipe_column_gen #(
    .ROWS(ROWS), .GAP_ROWS(GAP_ROWS), .MARGIN(MARGIN),
    .PIPE_WIDTH(PIPE_WIDTH), .SPACING(SPACING), .LFSR_SEED(LFSR_SEED)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .step(step),
    .col_valid(col_valid), .col_data(col_data), .gap_top(gap_top),
    .pipe_start(pipe_start), .pipe_count(pipe_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx     = PIPE_WIDTH;
    m_lfsr    = int'(LFSR_SEED);
    m_gap     = 0;
    m_count   = 0;
    exp_data  = 0;
    exp_valid = 0;
    exp_start = 0;
  endtask

  // One accepted step, computed from the column-period rules.
  task automatic model_step();
    int v;
    int fb;
    exp_valid = 1;
    exp_start = 0;
    if (m_idx == 0) begin
      v = m_lfsr % 32;
      if (v >= R) v = v - R;
      m_gap = MARGIN + v;
      fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
      m_lfsr = ((m_lfsr * 2) % 65536) + fb;
      m_count = (m_count < 255) ? m_count + 1 : 255;
      exp_start = 1;
    end
    if (m_idx < PIPE_WIDTH)
      exp_data = ((longint'(1) << ROWS) - 1) ^ (((longint'(1) << GAP_ROWS) - 1) << m_gap);
    else
      exp_data = 0;
    m_idx = (m_idx + 1) % SPACING;
  endtask

  task automatic check_outputs();
    check_eq("col_valid",  64'(col_valid),  64'(exp_valid));
    check_eq("col_data",   64'(col_data),   64'(exp_data));
    check_eq("pipe_start", 64'(pipe_start), 64'(exp_start));
    check_eq("pipe_count", 64'(pipe_count), 64'(m_count));
    check_eq("gap_top",    64'(gap_top),    64'(m_gap));
    if (col_valid && pipe_start) begin
      check_eq("gap_in_range", 64'((gap_top >= 5'd2) && (gap_top <= 5'd20)), 64'd1);
      check_eq("gap_zeros",    64'($countones(~col_data)), 64'(GAP_ROWS));
    end
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, check outputs.
  task automatic tick(input bit en, input bit st);
    enable = en;
    step   = st;
    @(posedge clk);
    if (en && st) model_step();
    else begin
      exp_valid = 0;
      exp_start = 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  int saved_idx;

  initial begin
    resetn = 1'b1;
    enable = 1'b0;
    step   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    resetn = 1'b0;
    @(negedge clk);

    // Steps while disabled are dropped.
    repeat (5) tick(1'b0, 1'b1);

    // Nine sky columns, each step followed by an idle cycle.
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
    end
    // First pipe: seed gives gap_top 3, bits 3..10 open.
    tick(1'b1, 1'b1);
    check_eq("first_gap",  64'(gap_top),  64'd3);
    check_eq("first_col",  64'(col_data), 64'h3FFFF807);
    check_eq("first_cnt",  64'(pipe_count), 64'd1);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      check_eq("pipe_repeat", 64'(col_data), 64'h3FFFF807);
    end
    // Sky up to and including the second pipe start (steps 13..22).
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
    end
    check_eq("second_start", 64'(pipe_start), 64'd1);

    // Freeze mid-pipe, then a held step gives three consecutive columns.
    saved_idx = m_idx;
    repeat (5) tick(1'b0, 1'b1);
    check_eq("frozen_idx", 64'(m_idx), 64'(saved_idx));
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);

    // Advance to just after a pipe's first column, then reset asynchronously.
    for (int i = 0; i < 2*SPACING && m_idx != 1; i++) tick(1'b1, 1'b1);
    check_eq("pre_reset_start", 64'(pipe_start), 64'd1);
    #2 resetn = 1'b1;
    #1;
    check_eq("async_valid", 64'(col_valid),  64'd0);
    check_eq("async_data",  64'(col_data),   64'd0);
    check_eq("async_count", 64'(pipe_count), 64'd0);
    check_eq("async_gap",   64'(gap_top),    64'd0);
    check_eq("async_start", 64'(pipe_start), 64'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b0;
    for (int i = 0; i < 9; i++) tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check_eq("post_reset_gap", 64'(gap_top), 64'd3);

    // Random enable/step traffic.
    for (int i = 0; i < 3000; i++)
      tick(1'(($urandom % 4) != 0), 1'($urandom % 2));

    // Long continuous run: over 1000 pipes, saturating the pipe counter.
    for (int i = 0; i < 1000*SPACING; i++) tick(1'b1, 1'b1);
    check_eq("count_saturated", 64'(pipe_count), 64'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_column_gen.md
Name: pipe_column_gen

Overview:
- Upstream feeder for the 30-row × 40-column obstacle shift-register playfield. One new 30-bit column enters on each game step.
- Each step, the block emits one column: either empty sky, or a pipe with a randomly placed vertical gap. A pipe is PIPE_WIDTH columns wide and pipes repeat every SPACING columns.
- Column bit r drives data_in of row-register r; the block also produces the shift strobe.
- Also exports the current gap position and a pipe counter for collision and score logic.

Parameters:
- ROWS, 30, playfield rows (column width in bits).
- GAP_ROWS, 8, rows left open in each pipe.
- MARGIN, 2, minimum solid rows above and below the gap.
- PIPE_WIDTH, 3, consecutive pipe columns per pipe.
- SPACING, 12, column period from the start of one pipe to the start of the next; must be > PIPE_WIDTH.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous, active-high reset. Despite the name, resetn=1 resets.
- enable  in  1  game running; step is ignored while low.
- step  in  1  one-cycle pulse from the frame tick; requests one column.
- col_valid  out  1  one-cycle shift strobe to the row registers.
- col_data  out  ROWS  column bits; 1 = obstacle, bit 0 = top row.
- gap_top  out  5  first open row of the most recently started pipe.
- pipe_start  out  1  pulses with col_valid on the first column of each pipe.
- pipe_count  out  8  number of pipes started since reset; saturates at 255.

Behaviour:
- Reset (async; resetn high), all of the following apply immediately:
  - col_valid=0, col_data=0, pipe_start=0, pipe_count=0, gap_top=0.
  - lfsr=LFSR_SEED, col_cnt=PIPE_WIDTH, state=EMPTY.
  - This applies regardless of state, including mid-pipe; no partial column is emitted after reset.
- Derived constant R = ROWS-GAP_ROWS-2*MARGIN+1.
  - Elaboration must fail unless 16 ≤ R ≤ 32.
  - R = 19 at the default parameters.
- States:
  - EMPTY: col_cnt in [PIPE_WIDTH, SPACING-1].
  - PIPE: col_cnt in [0, PIPE_WIDTH-1].
  - col_cnt is the column index within the period; state is a function of col_cnt.
- Accepted step: step=1 and enable=1 on a rising clk edge. A step while enable=0 is dropped with no state change, and outputs keep their reset or idle values.
- Column emitted for an accepted step (registered, latency 1):
  - col_valid=1 in the cycle after the accepted step; low in every other cycle.
  - col_data is driven with the column below and held unchanged until the next emission.
  - If col_cnt==0 (pipe start):
    - v = lfsr[4:0]; if v ≥ R then v = v-R.
    - gap_top = MARGIN + v.
    - col_data[r] = 0 for gap_top ≤ r ≤ gap_top+GAP_ROWS-1, and 1 for all other r.
    - pipe_start=1; pipe_count increments unless already 255.
    - lfsr advances one Fibonacci step: polynomial x^16+x^14+x^13+x^11+1, shift left, new bit0 = b15^b13^b12^b10.
    - The LFSR changes only here.
  - If 0 < col_cnt < PIPE_WIDTH: col_data uses the same gap_top as the pipe start (no redraw); pipe_start=0.
  - If col_cnt ≥ PIPE_WIDTH: col_data=0 (sky); pipe_start=0.
  - After emission: col_cnt = (col_cnt==SPACING-1) ? 0 : col_cnt+1.
- Back-to-back steps on consecutive cycles are legal. Each produces one column and col_valid stays high for consecutive cycles.
- Step asserted for N cycles counts as N steps.
- gap_top is stable between pipe starts; collision logic may sample it at any time.
- Dropping enable mid-pipe freezes col_cnt. When enable returns, the remaining pipe columns are emitted with the unchanged gap_top.

Test Plan:
- Reset, enable=1, 9 steps -> 9 col_valid pulses, each 1 cycle after its step; col_data=0 each time; pipe_start never high; pipe_count=0.
- 10th step -> col_data has bits 3..10 = 0 and all other bits = 1 (seed v=1, gap_top=3); pipe_start=1; pipe_count=1; steps 11 and 12 give the identical column with pipe_start=0.
- Steps 13-21 -> sky columns; step 22 -> second pipe whose gap_top equals MARGIN plus the reduced lfsr[4:0] of seed advanced once (scoreboard model); gap_top is in 2..20 for all pipes over 1000 pipes, and the gap is always exactly 8 zeros.
- step held high 5 cycles with enable=0 -> no col_valid, col_cnt unchanged; enable=1 with step held 3 cycles -> col_valid high for exactly 3 consecutive cycles.
- resetn pulsed high between the pipe's 1st and 2nd column (async, mid-cycle) -> outputs go to 0 immediately; next 9 steps are sky and the 10th gives gap_top=3 again.
- 300 pipes -> pipe_count saturates at 255 and stays there.
